loudness_meter_ph: RTL and testbench
====================================

LOUDNESS_METER_PH -- requirements
Module: loudness_meter_ph

Interface
REQ-001 SHALL have parameter DATA_W, default 16, input sample width (signed two's complement).
REQ-002 SHALL have parameter NLEDS, default 16, bar-graph LED count.
REQ-003 SHALL have parameter ALPHA_SHIFT, default 4, IIR decay: acc loses acc>>ALPHA_SHIFT per sample.
REQ-004 SHALL have parameter HOLD_SAMPLES, default 4096, accepted samples a new peak is held before decay starts.
REQ-005 SHALL have parameter DECAY_SAMPLES, default 512, accepted samples per one-step peak decrement.
REQ-006 SHALL have ports: clk  in  1  clock; arstn  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports: clr  in  1  synchronous clear; data  in  DATA_W  signed sample; data_valid  in  1; data_ready  out  1.
REQ-008 SHALL have ports: level  out  LW=$clog2(DATA_W+1)  log2 level; peak  out  LW  held peak; led  out  NLEDS  bar+peak display; out_valid  out  1; out_ready  in  1.

Function
REQ-009 SHALL be a 3-stage valid/ready pipeline (abs, filter, log+peak); each stage register SHALL load only when its input is valid and its ready is high; stage ready = downstream ready OR NOT stage valid.
REQ-010 SHALL give latency 3 cycles from data accepted to out_valid with out_ready held high; throughput 1 sample/cycle.
REQ-011 SHALL hold all stage data, acc, peak and counters unchanged while the stage holding them is stalled; out_valid, once high, SHALL stay high with stable outputs until out_ready.
REQ-012 Stage 1 SHALL compute |data| as unsigned DATA_W-1 bits, saturating the most negative input to 2^(DATA_W-1)-1.
REQ-013 Stage 2 SHALL update acc (DATA_W-1+ALPHA_SHIFT bits, unsigned) per accepted sample: acc = acc - (acc>>ALPHA_SHIFT) + abs, saturating at all-ones; filtered = acc>>ALPHA_SHIFT.
REQ-014 Stage 3 SHALL compute level = index of MSB of filtered plus 1, 0 when filtered is 0 (range 0..DATA_W-1).
REQ-015 Stage 3 bar = min(level, NLEDS); led[i] SHALL be 1 for i < bar (led[0] lowest), OR'd with led[peak-1] when 0 < peak <= NLEDS.
REQ-016 Peak FSM states HOLD and DECAY, evaluated per sample accepted into stage 3:
- level >= peak: peak = level, hold counter = HOLD_SAMPLES-1, state HOLD, decay counter = 0.
- HOLD, level < peak: hold counter decrements; at 0 goes to DECAY.
- DECAY, level < peak: decay counter increments; on reaching DECAY_SAMPLES-1 it wraps to 0 and peak decrements by 1 (never below level, never below 0).
- peak = 0 in DECAY: stays DECAY, counters idle.
REQ-017 peak output SHALL reflect the value after the update for the sample presented on out_valid.
REQ-018 clr high SHALL, on that clock edge: clear all stage valids, acc, peak, counters and state (DECAY, peak 0); data_ready SHALL be 0 while clr is high; samples offered during clr SHALL be dropped.
REQ-019 clr together with a pending output SHALL discard that output (out_valid 0 next cycle).

Reset
REQ-020 arstn low SHALL asynchronously force out_valid 0, level 0, peak 0, led 0, acc 0, all stage valids 0, counters 0, state DECAY.
REQ-021 data_ready SHALL be 1 in the first cycle after arstn deassertion (pipeline empty, clr low).
REQ-022 Reset asserted mid-stream SHALL discard all in-flight samples; no out_valid until 3 cycles after the first accepted post-reset sample.

Verification
REQ-023 Defaults, out_ready=1, constant data=1024 for 200 samples -> filtered converges to 1024 (within 1), level=11, led=0x07FF, peak=11.
REQ-024 data=-32768 single sample after reset -> stage-1 abs=32767, no overflow; acc=32767 then decays by 1/16 per zero sample.
REQ-025 HOLD_SAMPLES=8, DECAY_SAMPLES=4: level 11 then zeros until level reaches 0 -> peak=11 for 8 samples after the peak sample, then decrements by 1 every 4 samples, never below current level.
REQ-026 out_ready low 10 cycles with data_valid high -> data_ready falls after 3 samples accepted; outputs stable; no samples lost or duplicated when released (compare against reference model).
REQ-027 clr pulse during stream with out_valid high -> next cycle out_valid=0, peak=0, acc=0; data_ready=0 during clr.
REQ-028 arstn asserted mid-burst -> all outputs 0 immediately (asynchronous); first output exactly 3 cycles after first post-reset accepted sample.

Source files
------------

// File: rtl/loudness_meter_ph.sv
// Audio loudness meter: |x| -> leaky-integrator envelope -> log2 level with
// peak-hold/decay, shown as a bar-graph LED word. 3-stage valid/ready pipeline.
module loudness_meter_ph #(
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned NLEDS         = 16,
  parameter int unsigned ALPHA_SHIFT   = 4,
  parameter int unsigned HOLD_SAMPLES  = 4096,
  parameter int unsigned DECAY_SAMPLES = 512,
  localparam int unsigned LW           = $clog2(DATA_W + 1)
) (
  input  logic                     clk,
  input  logic                     arstn,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] data,
  input  logic                     data_valid,
  output logic                     data_ready,
  output logic [LW-1:0]            level,
  output logic [LW-1:0]            peak,
  output logic [NLEDS-1:0]         led,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int unsigned FW  = DATA_W - 1;
  localparam int unsigned AW  = DATA_W - 1 + ALPHA_SHIFT;
  localparam int unsigned HCW = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
  localparam int unsigned DCW = (DECAY_SAMPLES > 1) ? $clog2(DECAY_SAMPLES) : 1;

  typedef enum logic {ST_HOLD = 1'b0, ST_DECAY = 1'b1} pk_state_e;

  logic            s1_valid_q, s2_valid_q, out_valid_q;
  logic [FW-1:0]   s1_abs_q, s2_filt_q;
  logic [AW-1:0]   acc_q, acc_d;
  logic [LW-1:0]   level_q, peak_q;
  logic [NLEDS-1:0] led_q;
  pk_state_e       state_q;
  logic [HCW-1:0]  hold_q;
  logic [DCW-1:0]  decay_q;

  logic            s1_ready_c, s2_ready_c, s3_ready_c;
  logic [DATA_W-1:0] data_u_c;
  logic [FW-1:0]   neg_c, abs_c, filt_c;
  logic [AW-1:0]   acc_dec_c;
  logic [AW:0]     sum_c;
  logic [LW-1:0]   level_c, peak_upd_c;
  logic            load_c, dec_c;
  logic [NLEDS-1:0] led_c;

  // A stage accepts when it is empty or its content moves on this edge.
  assign s3_ready_c = out_ready | ~out_valid_q;
  assign s2_ready_c = s3_ready_c | ~s2_valid_q;
  assign s1_ready_c = s2_ready_c | ~s1_valid_q;
  assign data_ready = s1_ready_c & ~clr;

  assign out_valid = out_valid_q;
  assign level     = level_q;
  assign peak      = peak_q;
  assign led       = led_q;

  // Magnitude; the most negative code saturates to the largest positive one.
  always_comb begin
    data_u_c = data;
    neg_c    = ~data_u_c[FW-1:0] + FW'(1);
    abs_c    = data_u_c[FW-1:0];
    if (data_u_c[DATA_W-1]) begin
      abs_c = (data_u_c[FW-1:0] == '0) ? '1 : neg_c;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      s1_valid_q <= 1'b0;
      s1_abs_q   <= '0;
    end else if (clr) begin
      s1_valid_q <= 1'b0;
    end else if (s1_ready_c) begin
      s1_valid_q <= data_valid;
      if (data_valid) s1_abs_q <= abs_c;
    end
  end

  // Envelope: acc += abs - acc/2^ALPHA_SHIFT, clamped at all-ones.
  always_comb begin
    acc_dec_c = acc_q - (acc_q >> ALPHA_SHIFT);
    sum_c     = {1'b0, acc_dec_c} + {{(ALPHA_SHIFT + 1){1'b0}}, s1_abs_q};
    acc_d     = sum_c[AW] ? '1 : sum_c[AW-1:0];
    filt_c    = acc_d[AW-1:ALPHA_SHIFT];
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      s2_valid_q <= 1'b0;
      s2_filt_q  <= '0;
      acc_q      <= '0;
    end else if (clr) begin
      s2_valid_q <= 1'b0;
      acc_q      <= '0;
    end else if (s2_ready_c) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        acc_q     <= acc_d;
        s2_filt_q <= filt_c;
      end
    end
  end

  // Level, updated peak and LED word for the sample entering stage 3.
  always_comb begin
    level_c = '0;
    for (int unsigned i = 0; i < FW; i++) begin
      if (s2_filt_q[i]) level_c = LW'(i + 1);
    end
    load_c = (level_c >= peak_q) && (level_c != '0);
    dec_c  = !load_c && (level_c < peak_q) && (state_q == ST_DECAY) &&
             (decay_q == DCW'(DECAY_SAMPLES - 1));
    peak_upd_c = peak_q;
    if (load_c)     peak_upd_c = level_c;
    else if (dec_c) peak_upd_c = peak_q - LW'(1);
    led_c = '0;
    for (int unsigned i = 0; i < NLEDS; i++) begin
      led_c[i] = (i < 32'(level_c)) || (32'(peak_upd_c) == i + 32'd1);
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      out_valid_q <= 1'b0;
      level_q     <= '0;
      peak_q      <= '0;
      led_q       <= '0;
      state_q     <= ST_DECAY;
      hold_q      <= '0;
      decay_q     <= '0;
    end else if (clr) begin
      out_valid_q <= 1'b0;
      level_q     <= '0;
      peak_q      <= '0;
      led_q       <= '0;
      state_q     <= ST_DECAY;
      hold_q      <= '0;
      decay_q     <= '0;
    end else if (s3_ready_c) begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        level_q <= level_c;
        peak_q  <= peak_upd_c;
        led_q   <= led_c;
        if (load_c) begin
          state_q <= ST_HOLD;
          hold_q  <= HCW'(HOLD_SAMPLES - 1);
          decay_q <= '0;
        end else if (level_c < peak_q) begin
          case (state_q)
            ST_HOLD: begin
              if (hold_q == '0) state_q <= ST_DECAY;
              else              hold_q  <= hold_q - HCW'(1);
            end
            ST_DECAY: begin
              if (decay_q == DCW'(DECAY_SAMPLES - 1)) decay_q <= '0;
              else                                    decay_q <= decay_q + DCW'(1);
            end
            default: state_q <= ST_DECAY;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_loudness_meter_ph.sv
// Bench for loudness_meter_ph: directed phases with random samples, every
// output handshake checked against an arithmetic model of the meter.
module tb_loudness_meter_ph;

  localparam int unsigned DW = 16;
  localparam int unsigned NL = 16;
  localparam int unsigned AS = 4;
  localparam int unsigned HS = 8;
  localparam int unsigned DS = 4;
  localparam int unsigned LW = 5;
  localparam int AMAX = int'((1 << (DW - 1 + AS)) - 1);

  typedef struct packed {
    logic [LW-1:0] lvl;
    logic [LW-1:0] pk;
    logic [NL-1:0] led;
  } exp_t;

  logic clk, arstn, clr, data_valid, data_ready, out_valid, out_ready;
  logic signed [DW-1:0] data;
  logic [LW-1:0] level, peak;
  logic [NL-1:0] led;

  int   n_chk = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  exp_t q[$];
  int   m_acc, m_pk, m_n;
  bit   hold_chk;
  exp_t sv, mon_e;
  int   n_acc;

  loudness_meter_ph #(
    .DATA_W(DW), .NLEDS(NL), .ALPHA_SHIFT(AS),
    .HOLD_SAMPLES(HS), .DECAY_SAMPLES(DS)
  ) dut (
    .clk(clk), .arstn(arstn), .clr(clr), .data(data),
    .data_valid(data_valid), .data_ready(data_ready),
    .level(level), .peak(peak), .led(led),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_chk++;
    assert (obs === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, want);
    end
  endtask

  task automatic model_clear();
    m_acc = 0;
    m_pk  = 0;
    m_n   = 0;
  endtask

  // Reference meter: integer envelope, level = bit length, peak by time since load.
  task automatic model_accept(input int d);
    int a, filt, lvl;
    logic [31:0] m;
    exp_t e;
    a = (d < 0) ? -d : d;
    if (a > 32767) a = 32767;
    m_acc = m_acc - (m_acc >> AS) + a;
    if (m_acc > AMAX) m_acc = AMAX;
    filt = m_acc >> AS;
    lvl = 0;
    while ((1 << lvl) <= filt) lvl++;
    if (lvl >= m_pk && lvl != 0) begin
      m_pk = lvl;
      m_n  = 0;
    end else if (lvl < m_pk) begin
      m_n++;
      if (m_n > int'(HS) && (m_n - int'(HS)) % int'(DS) == 0) m_pk--;
    end
    m = (lvl >= int'(NL)) ? '1 : (32'd1 << lvl) - 32'd1;
    if (m_pk > 0 && m_pk <= int'(NL)) m[m_pk-1] = 1'b1;
    e.lvl = LW'(lvl);
    e.pk  = LW'(m_pk);
    e.led = m[NL-1:0];
    q.push_back(e);
  endtask

  function automatic logic signed [DW-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'sh8000;
      1:       return 16'sh7FFF;
      2:       return '0;
      default: return DW'($urandom);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int n, input bit rnd_valid, input bit rnd_ready);
    for (int i = 0; i < n; i++) begin
      data       = pick();
      data_valid = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      out_ready  = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      step();
    end
  endtask

  task automatic drain();
    data_valid = 1'b0;
    out_ready  = 1'b1;
    repeat (6) step();
    chk("drain_empty", 64'(q.size()), 64'(0));
  endtask

  task automatic do_clr();
    clr        = 1'b1;
    data_valid = 1'b0;
    step();
    clr        = 1'b0;
  endtask

  // Output monitor and scoreboard, sampling on the falling edge.
  initial begin
    hold_chk = 1'b0;
    forever begin
      @(negedge clk);
      if (!arstn) begin
        hold_chk = 1'b0;
      end else if (clr) begin
        q.delete();
        model_clear();
        hold_chk = 1'b0;
      end else begin
        if (hold_chk)
          chk("stall_hold", 64'({out_valid, level, peak, led}), 64'({1'b1, sv}));
        if (out_valid && out_ready) begin
          chk("out_expected", 64'(q.size() != 0), 64'(1));
          if (q.size() != 0) begin
            mon_e = q.pop_front();
            chk("out_level", 64'(level), 64'(mon_e.lvl));
            chk("out_peak",  64'(peak),  64'(mon_e.pk));
            chk("out_led",   64'(led),   64'(mon_e.led));
          end
          hold_chk = 1'b0;
        end else if (out_valid) begin
          sv       = {level, peak, led};
          hold_chk = 1'b1;
        end
        if (data_valid && data_ready) model_accept(int'(data));
      end
    end
  end

  initial begin
    clr = 1'b0; data = '0; data_valid = 1'b0; out_ready = 1'b1; arstn = 1'b1;
    model_clear();
    #2 arstn = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_peak", 64'(peak), 64'(0));
    chk("rst_led", 64'(led), 64'(0));
    chk("rst_acc", 64'(dut.acc_q), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #3 arstn = 1'b1;
    #1 chk("ready_after_rst", 64'(data_ready), 64'(1));
    step();

    // Most negative sample, then zeros: saturating magnitude and 1/16 decay.
    data = 16'sh8000; data_valid = 1'b1;
    step();
    chk("lat1_out_valid", 64'(out_valid), 64'(0));
    data = '0;
    step();
    chk("lat2_out_valid", 64'(out_valid), 64'(0));
    chk("acc_after_min", 64'(dut.acc_q), 64'(32767));
    step();
    chk("lat3_out_valid", 64'(out_valid), 64'(1));
    chk("level_after_min", 64'(level), 64'(11));
    chk("acc_first_decay", 64'(dut.acc_q), 64'(30720));
    repeat (30) step();
    drain();

    // Constant 1024 converges to level 11.
    do_clr();
    data = 16'sd1024; data_valid = 1'b1;
    repeat (200) step();
    drain();
    chk("const_level", 64'(level), 64'(11));
    chk("const_peak", 64'(peak), 64'(11));
    chk("const_led", 64'(led), 64'(16'h07FF));

    // Loud sample then silence: hold then stepwise peak decay to zero.
    do_clr();
    data = 16'sh7FFF; data_valid = 1'b1;
    step();
    data = '0;
    repeat (150) step();
    drain();
    chk("silence_level", 64'(level), 64'(0));
    chk("silence_peak", 64'(peak), 64'(0));

    // Back-pressure: three samples fill the pipe, then input stalls.
    out_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      data = pick(); data_valid = 1'b1;
      #1;
      if (data_ready) n_acc++;
      step();
    end
    chk("accepted_before_stall", 64'(n_acc), 64'(3));
    chk("ready_low_stalled", 64'(data_ready), 64'(0));
    stream(40, 1'b1, 1'b1);
    drain();

    // Synchronous clear with a pending output.
    stream(12, 1'b0, 1'b0);
    chk("ov_before_clr", 64'(out_valid), 64'(1));
    clr = 1'b1;
    #1 chk("ready_in_clr", 64'(data_ready), 64'(0));
    step();
    clr = 1'b0;
    chk("clr_out_valid", 64'(out_valid), 64'(0));
    chk("clr_peak", 64'(peak), 64'(0));
    chk("clr_acc", 64'(dut.acc_q), 64'(0));
    stream(20, 1'b1, 1'b1);
    drain();

    // Asynchronous reset mid-burst.
    stream(8, 1'b0, 1'b0);
    #2 arstn = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_level", 64'(level), 64'(0));
    chk("mid_rst_peak", 64'(peak), 64'(0));
    chk("mid_rst_led", 64'(led), 64'(0));
    q.delete();
    model_clear();
    data_valid = 1'b0;
    @(posedge clk);
    #3 arstn = 1'b1;
    #1 data = pick(); data_valid = 1'b1; out_ready = 1'b1;
    step();
    chk("post_rst_lat1", 64'(out_valid), 64'(0));
    data = pick();
    step();
    chk("post_rst_lat2", 64'(out_valid), 64'(0));
    data = pick();
    step();
    chk("post_rst_lat3", 64'(out_valid), 64'(1));
    stream(20, 1'b1, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
